// File: rtl/cordic_atan2_if.sv
// Handshake bundle for cordic_atan2: x/y request side and angle/magnitude result side.
interface cordic_atan2_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 9
);
    localparam int unsigned MW = ((XW > YW) ? XW : YW) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [XW-1:0] x;
    logic signed [YW-1:0] y;
    logic                 out_valid;
    logic                 out_ready;
    logic [8:0]           angle;
    logic [MW-1:0]        magnitude;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, angle, magnitude
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, angle, magnitude
    );
endinterface

// File: rtl/cordic_atan2.sv
// Iterative CORDIC vectoring engine: signed (x, y) -> angle in whole degrees and magnitude.
// One micro-rotation per cycle; a single operation is in flight at a time.
module cordic_atan2 #(
    parameter int unsigned XW   = 10,
    parameter int unsigned YW   = 9,
    parameter int unsigned ITER = 12,
    parameter int unsigned FRAC = 8
) (
    input logic            clk,
    input logic            rst_n,
    cordic_atan2_if.slave  bus
);
    localparam int unsigned MW = ((XW > YW) ? XW : YW) + 1;
    localparam int unsigned IW = MW + 1;
    // Fractional guard bits below the input LSB keep shift truncation out of the result.
    localparam int unsigned G  = 8;
    localparam int unsigned W  = IW + G;
    localparam int unsigned ZW = FRAC + 10;
    localparam int unsigned CW = $clog2(ITER + 1);
    localparam int unsigned LN = 1 << CW;
    localparam int unsigned PW = W + 16;

    // CORDIC gain reciprocal with 16 fractional bits; identical for every ITER in 8..16.
    localparam logic [15:0] KQ = 16'd39797;

    localparam int                   ZHALF_I = 1 << (FRAC - 1);
    localparam logic signed [ZW-1:0] ZHALF   = ZW'(ZHALF_I);
    localparam int                   MHALF_I = 1 << (15 + G);
    localparam int unsigned          MMAX_I  = (1 << MW) - 1;

    // atan(2^-i) in degrees, scaled by 2^24.
    function automatic logic [31:0] atan_deg_q24(input int unsigned i);
        logic [31:0] t;
        case (i)
            0:       t = 32'd754974720;
            1:       t = 32'd445687602;
            2:       t = 32'd235489088;
            3:       t = 32'd119537938;
            4:       t = 32'd60000934;
            5:       t = 32'd30029717;
            6:       t = 32'd15018523;
            7:       t = 32'd7509720;
            8:       t = 32'd3754917;
            9:       t = 32'd1877466;
            10:      t = 32'd938734;
            11:      t = 32'd469367;
            12:      t = 32'd234684;
            13:      t = 32'd117342;
            14:      t = 32'd58671;
            15:      t = 32'd29335;
            default: t = 32'd0;
        endcase
        return t;
    endfunction

    function automatic logic [LN-1:0][ZW-1:0] build_lut();
        logic [LN-1:0][ZW-1:0] lut;
        logic [63:0]           t;
        for (int unsigned i = 0; i < LN; i++) begin
            t      = 64'(atan_deg_q24(i));
            lut[i] = ZW'(((t << FRAC) + 64'd8388608) >> 24);
        end
        return lut;
    endfunction

    localparam logic [LN-1:0][ZW-1:0] ATAN_LUT = build_lut();

    typedef enum logic [1:0] {StIdle, StRot, StDone} state_e;

    state_e               state_q;
    logic [CW-1:0]        i_q;
    logic signed [W-1:0]  x_q, y_q;
    logic signed [ZW-1:0] z_q;
    logic                 off_q, zero_q;
    logic                 in_ready_q, out_valid_q;
    logic [8:0]           angle_q;
    logic [MW-1:0]        mag_q;

    // Input fold into the right half-plane.
    logic signed [IW-1:0] x_ext, y_ext, x_f, y_f;
    logic                 x_neg, in_zero;
    logic signed [W-1:0]  x_load, y_load;

    always_comb begin
        x_ext   = {{(IW - XW){bus.x[XW-1]}}, bus.x};
        y_ext   = {{(IW - YW){bus.y[YW-1]}}, bus.y};
        x_neg   = x_ext[IW-1];
        x_f     = x_neg ? -x_ext : x_ext;
        y_f     = x_neg ? -y_ext : y_ext;
        in_zero = (x_ext == '0) && (y_ext == '0);
        x_load  = {x_f, {G{1'b0}}};
        y_load  = {y_f, {G{1'b0}}};
    end

    logic signed [W-1:0]  x_sh, y_sh, x_rot, y_rot;
    logic signed [ZW-1:0] step, z_rot;

    always_comb begin
        x_sh = x_q >>> i_q;
        y_sh = y_q >>> i_q;
        step = ATAN_LUT[i_q];
        if (!y_q[W-1]) begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + step;
        end else begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - step;
        end
    end

    logic signed [ZW-1:0] z_sum, z_rnd;
    logic signed [10:0]   a_s;
    logic [8:0]           angle_calc;
    logic [W-1:0]         x_u;
    logic [PW-1:0]        prod, rnd, mag_full;
    logic [MW-1:0]        mag_calc;

    always_comb begin
        z_sum = z_q + ZHALF;
        z_rnd = z_sum >>> FRAC;
        a_s   = $signed(11'(z_rnd)) + (off_q ? 11'sd180 : 11'sd0);
        if (a_s < 0) begin
            a_s = a_s + 11'sd360;
        end
        if (a_s == 11'sd360 || zero_q) begin
            a_s = '0;
        end
        angle_calc = 9'(a_s);

        x_u      = x_q[W-1] ? '0 : x_q;
        prod     = PW'(x_u) * PW'(KQ);
        rnd      = prod + PW'(MHALF_I);
        mag_full = rnd >> (16 + G);
        mag_calc = (mag_full > PW'(MMAX_I)) ? {MW{1'b1}} : MW'(mag_full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            i_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            off_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            angle_q     <= '0;
            mag_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        x_q        <= x_load;
                        y_q        <= y_load;
                        z_q        <= '0;
                        i_q        <= '0;
                        off_q      <= x_neg;
                        zero_q     <= in_zero;
                        in_ready_q <= 1'b0;
                        state_q    <= StRot;
                    end
                end
                StRot: begin
                    // Extra cycle after the last rotation registers the results.
                    if (i_q == CW'(ITER)) begin
                        angle_q     <= angle_calc;
                        mag_q       <= mag_calc;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        x_q <= x_rot;
                        y_q <= y_rot;
                        z_q <= z_rot;
                        i_q <= i_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.angle     = angle_q;
    assign bus.magnitude = mag_q;
endmodule

// File: tb/tb_cordic_atan2.sv
// Self-checking bench for cordic_atan2: directed table, handshake corners, grid and random sweep
// against a real-valued atan2/sqrt reference.
module tb_cordic_atan2;
    localparam int unsigned XW   = 10;
    localparam int unsigned YW   = 9;
    localparam int unsigned ITER = 12;
    localparam int unsigned FRAC = 8;
    localparam real         PI   = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_atan2_if #(.XW(XW), .YW(YW)) bif ();

    cordic_atan2 #(.XW(XW), .YW(YW), .ITER(ITER), .FRAC(FRAC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    typedef struct {
        int x;
        int y;
        int ang;
        int mag;
    } vec_t;

    vec_t tbl[9];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp, input int tol,
                       input bit circ);
        int d;
        d = act - exp;
        if (d < 0) d = -d;
        if (circ) begin
            if (act < 0 || act > 359) d = 999;
            else if (d > 180) d = 360 - d;
        end
        n_checks++;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
    endtask

    function automatic int ref_angle(input int x, input int y);
        real d;
        int  r;
        d = $atan2(real'(y), real'(x)) * 180.0 / PI;
        r = int'(d);
        return ((r % 360) + 360) % 360;
    endfunction

    function automatic int ref_mag(input int x, input int y);
        return int'($sqrt(real'(x * x + y * y)));
    endfunction

    // One full transaction with out_ready assumed high; bounded waits.
    task automatic do_op(input int xi, input int yi, output int a, output int m);
        int n;
        @(negedge clk);
        bif.x        = XW'(xi);
        bif.y        = YW'(yi);
        bif.in_valid = 1'b1;
        n = 0;
        while (!bif.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        n = 0;
        while (!bif.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bif.out_valid) begin
            n_checks++;
            $display("FAIL timeout (%0d,%0d): out_valid got 0, want 1", xi, yi);
        end
        a = int'(bif.angle);
        m = int'(bif.magnitude);
        @(posedge clk);
        #1;
    endtask

    task automatic model_op(input string tag, input int xi, input int yi);
        int a, m;
        do_op(xi, yi, a, m);
        chk($sformatf("%s ang(%0d,%0d)", tag, xi, yi), a, ref_angle(xi, yi), 1, 1'b1);
        chk($sformatf("%s mag(%0d,%0d)", tag, xi, yi), m, ref_mag(xi, yi), 2, 1'b0);
    endtask

    initial begin
        int a, m, k, bad;
        int a0, m0;
        logic [31:0] r;

        tbl[0] = '{x: 100,  y: 0,    ang: 0,   mag: 100};
        tbl[1] = '{x: 0,    y: 100,  ang: 90,  mag: 100};
        tbl[2] = '{x: -100, y: 0,    ang: 180, mag: 100};
        tbl[3] = '{x: 0,    y: -100, ang: 270, mag: 100};
        tbl[4] = '{x: 100,  y: 100,  ang: 45,  mag: 141};
        tbl[5] = '{x: -512, y: -256, ang: 207, mag: 572};
        tbl[6] = '{x: -512, y: 0,    ang: 180, mag: 512};
        tbl[7] = '{x: 1,    y: -1,   ang: 315, mag: 1};
        tbl[8] = '{x: 0,    y: 0,    ang: 0,   mag: 0};

        rst_n         = 1'b0;
        bif.in_valid  = 1'b0;
        bif.x         = '0;
        bif.y         = '0;
        bif.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst in_ready", int'(bif.in_ready), 1, 0, 1'b0);
        chk("rst out_valid", int'(bif.out_valid), 0, 0, 1'b0);
        chk("rst angle", int'(bif.angle), 0, 0, 1'b0);
        chk("rst magnitude", int'(bif.magnitude), 0, 0, 1'b0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            do_op(tbl[i].x, tbl[i].y, a, m);
            chk($sformatf("tbl ang(%0d,%0d)", tbl[i].x, tbl[i].y), a, tbl[i].ang, 0, 1'b1);
            chk($sformatf("tbl mag(%0d,%0d)", tbl[i].x, tbl[i].y), m, tbl[i].mag, 0, 1'b0);
        end

        // Latency: accept edge N, out_valid first seen after edge N+ITER+1.
        @(negedge clk);
        bif.x = 10'sd200;
        bif.y = 9'sd50;
        bif.in_valid = 1'b1;
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        chk("in_ready falls at accept", int'(bif.in_ready), 0, 0, 1'b0);
        k = 0;
        while (k < 40 && !bif.out_valid) begin
            @(posedge clk);
            #1 k++;
        end
        chk("latency edges", k, ITER + 1, 0, 1'b0);
        @(posedge clk);
        #1 chk("in_ready after handshake", int'(bif.in_ready), 1, 0, 1'b0);

        // in_valid pulses during rotation must be ignored.
        @(negedge clk);
        bif.x = 10'sd30;
        bif.y = 9'sd40;
        bif.in_valid = 1'b1;
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        bif.x = -10'sd200;
        bif.y = -9'sd100;
        bif.in_valid = 1'b1;
        chk("in_ready low in ROT", int'(bif.in_ready), 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        bif.in_valid = 1'b0;
        k = 0;
        while (k < 40 && !bif.out_valid) begin
            @(negedge clk);
            k++;
        end
        chk("ignore ang", int'(bif.angle), 53, 0, 1'b1);
        chk("ignore mag", int'(bif.magnitude), 50, 0, 1'b0);
        @(posedge clk);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bif.out_valid) bad++;
        end
        chk("no second result", bad, 0, 0, 1'b0);

        // Backpressure: results and in_ready hold while out_ready is low.
        bif.out_ready = 1'b0;
        @(negedge clk);
        bif.x = 10'sd0;
        bif.y = 9'sd100;
        bif.in_valid = 1'b1;
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        k = 0;
        while (k < 40 && !bif.out_valid) begin
            @(negedge clk);
            k++;
        end
        a0 = int'(bif.angle);
        m0 = int'(bif.magnitude);
        chk("bp ang", a0, 90, 0, 1'b1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!bif.out_valid || bif.in_ready || int'(bif.angle) != a0 ||
                int'(bif.magnitude) != m0) bad++;
        end
        chk("bp stable cycles bad", bad, 0, 0, 1'b0);
        bif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release in_ready", int'(bif.in_ready), 1, 0, 1'b0);
        chk("bp release out_valid", int'(bif.out_valid), 0, 0, 1'b0);

        // Reset five cycles into rotation.
        @(negedge clk);
        bif.x = 10'sd100;
        bif.y = 9'sd100;
        bif.in_valid = 1'b1;
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", int'(bif.out_valid), 0, 0, 1'b0);
        chk("midrst in_ready", int'(bif.in_ready), 1, 0, 1'b0);
        chk("midrst angle", int'(bif.angle), 0, 0, 1'b0);
        chk("midrst magnitude", int'(bif.magnitude), 0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, -100, a, m);
        chk("post-rst ang", a, 270, 0, 1'b1);
        chk("post-rst mag", m, 100, 0, 1'b0);

        // Wrap region near +x axis.
        model_op("wrap", 511, -1);
        model_op("wrap", 400, -3);
        model_op("wrap", 300, 2);
        model_op("wrap", 97, -1);

        // Coarse grid across the full input range.
        for (int gx = -512; gx <= 511; gx += 31) begin
            for (int gy = -256; gy <= 255; gy += 31) begin
                model_op("grid", gx, gy);
            end
        end

        // Random points, sign-extended from raw bit patterns.
        for (int n = 0; n < 1000; n++) begin
            r = $urandom;
            model_op("rand", int'($signed(r[9:0])), int'($signed(r[18:10])));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
